x74_194_seq: RTL and testbench

Command sequencer driving a 4-bit 74194-style universal shift register. The block sits directly upstream of the register and owns its mode, serial, parallel and clear inputs. It accepts one command per valid/ready handshake (load, shift, rotate, clear) and runs the register for the requested number of clock edges. It then returns the register contents through a valid/ready response channel.

---
 rtl/x74_pkg.sv | 43 ++++
 rtl/x74_194.sv | 40 ++++
 rtl/x74_194_seq.sv | 135 +++++++++++++
 tb/tb_x74_194_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x74_pkg.sv
// Shared constants and types for the 74194 command sequencer.
package x74_pkg;

    // Command opcodes; 6 and 7 are illegal.
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_SHR   = 3'd1;
    localparam logic [2:0] OP_SHL   = 3'd2;
    localparam logic [2:0] OP_ROR   = 3'd3;
    localparam logic [2:0] OP_ROL   = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd5;

    // Register mode as {s1,s0}.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // True for the four ops that take a shift count.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    // Register mode used while an op is running. Right-moving ops share
    // MODE_SHR and left-moving ops share MODE_SHL; only the serial input differs.
    function automatic logic [1:0] op_mode(input logic [2:0] op);
        logic [1:0] m;
        m = MODE_HOLD;
        case (op)
            OP_LOAD:        m = MODE_LOAD;
            OP_SHR, OP_ROR: m = MODE_SHR;
            OP_SHL, OP_ROL: m = MODE_SHL;
            default:        m = MODE_HOLD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/x74_194.sv
// 4-bit 74194-style universal shift register: asynchronous active-low clear,
// hold / shift right (toward qd) / shift left (toward qa) / parallel load.
module x74_194
    import x74_pkg::*;
(
    input  logic ck,
    input  logic clr_n,
    input  logic s0,
    input  logic s1,
    input  logic sli,
    input  logic sri,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd
);

    logic [3:0] q;

    assign {qa, qb, qc, qd} = q;

    // Register update; clear overrides everything and does not wait for the clock.
    always_ff @(posedge ck or negedge clr_n) begin
        if (!clr_n) begin
            q <= 4'b0000;
        end else begin
            case ({s1, s0})
                MODE_SHR:  q <= {sri, q[3:1]};
                MODE_SHL:  q <= {q[2:0], sli};
                MODE_LOAD: q <= {a, b, c, d};
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/x74_194_seq.sv
// Command sequencer for a 74194-style shift register. Accepts one
// load/shift/rotate/clear command per handshake, drives the register's mode,
// serial, parallel and clear inputs for the requested number of edges, then
// presents the register contents on a valid/ready response channel.
module x74_194_seq
    import x74_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             ck,
    input  logic             clr,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_fill,
    // shift register outputs
    input  logic             qa,
    input  logic             qb,
    input  logic             qc,
    input  logic             qd,
    // shift register controls
    output logic             s0,
    output logic             s1,
    output logic             sli,
    output logic             sri,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             sr_clr_n,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_q,
    output logic             rsp_err
);

    state_t           state;
    logic [1:0]       mode;
    logic [3:0]       par;
    logic [2:0]       op_r;
    logic             fill_r;
    logic [CNT_W-1:0] cnt;
    logic             err_r;
    logic             clr_n_r;
    logic             rdy;

    assign {s1, s0}     = mode;
    assign {a, b, c, d} = par;
    assign sr_clr_n     = clr_n_r;
    assign cmd_ready    = rdy;
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_err      = err_r;

    // The register holds during RESP, so its outputs are a stable response.
    assign rsp_q = {qa, qb, qc, qd};

    // Rotates close the loop through the register itself; plain shifts feed
    // the fill bit captured with the command.
    assign sri = (op_r == OP_ROR) ? qd : fill_r;
    assign sli = (op_r == OP_ROL) ? qa : fill_r;

    // Command FSM: IDLE accepts, RUN counts register edges, RESP waits for the consumer.
    always_ff @(posedge ck) begin
        if (clr) begin
            state   <= ST_IDLE;
            mode    <= MODE_HOLD;
            par     <= 4'b0000;
            op_r    <= OP_LOAD;
            fill_r  <= 1'b0;
            cnt     <= '0;
            err_r   <= 1'b0;
            clr_n_r <= 1'b0;
            rdy     <= 1'b0;
        end else begin
            // Clear pulse lasts exactly one cycle unless re-armed below.
            clr_n_r <= 1'b1;
            case (state)
                ST_IDLE: begin
                    rdy <= 1'b1;
                    if (cmd_valid && rdy) begin
                        rdy    <= 1'b0;
                        par    <= cmd_data;
                        op_r   <= cmd_op;
                        fill_r <= cmd_fill;
                        cnt    <= (cmd_op == OP_LOAD) ? CNT_W'(1) : cmd_cnt;
                        if (cmd_op == OP_LOAD) begin
                            mode  <= MODE_LOAD;
                            state <= ST_RUN;
                        end else if (is_shift_op(cmd_op)) begin
                            // A zero count completes without touching the register.
                            if (cmd_cnt == '0) begin
                                state <= ST_RESP;
                            end else begin
                                mode  <= op_mode(cmd_op);
                                state <= ST_RUN;
                            end
                        end else if (cmd_op == OP_CLEAR) begin
                            clr_n_r <= 1'b0;
                            state   <= ST_RESP;
                        end else begin
                            err_r <= 1'b1;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RUN: begin
                    // Decrement saturates at zero; the last active edge is the one seeing 1.
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    if (cnt <= CNT_W'(1)) begin
                        mode  <= MODE_HOLD;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        err_r <= 1'b0;
                        rdy   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    mode  <= MODE_HOLD;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x74_194_seq.sv
// Bench for x74_194_seq driving an x74_194. Commands go through a driver that
// pushes expected responses into a scoreboard; a monitor pops them on each
// response handshake and also watches mode, feedback and response stability.
module tb_x74_194_seq;
    import x74_pkg::*;

    localparam int CNT_W = 3;

    logic             ck = 1'b0;
    logic             clr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [3:0]       cmd_data;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_fill;
    logic             qa, qb, qc, qd;
    logic             s0, s1, sli, sri;
    logic             a, b, c, d;
    logic             sr_clr_n;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [3:0]       rsp_q;
    logic             rsp_err;

    always #5 ck = ~ck;

    x74_194_seq #(.CNT_W(CNT_W)) dut (
        .ck(ck), .clr(clr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .cmd_fill(cmd_fill),
        .qa(qa), .qb(qb), .qc(qc), .qd(qd),
        .s0(s0), .s1(s1), .sli(sli), .sri(sri),
        .a(a), .b(b), .c(c), .d(d), .sr_clr_n(sr_clr_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err)
    );

    x74_194 sreg (
        .ck(ck), .clr_n(sr_clr_n), .s0(s0), .s1(s1), .sli(sli), .sri(sri),
        .a(a), .b(b), .c(c), .d(d), .qa(qa), .qb(qb), .qc(qc), .qd(qd)
    );

    typedef struct {
        int q;
        int err;
        int active;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         force_until = 0;
    int         mdl = 0;
    logic [2:0] cur_op = 3'd0;
    logic       cur_fill = 1'b0;

    always @(posedge ck) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: register value as a 4-bit number with qa as the MSB.
    function automatic exp_t apply(input logic [2:0] op, input logic [3:0] data,
                                   input int cnt, input logic fill);
        exp_t e;
        int   v;
        int   f;
        v = mdl;
        f = int'(fill);
        e.err = 0;
        e.active = 0;
        case (op)
            3'd0: begin v = int'(data); e.active = 1; end
            3'd1: begin for (int i = 0; i < cnt; i++) v = (f * 8) + (v / 2); e.active = cnt; end
            3'd2: begin for (int i = 0; i < cnt; i++) v = ((v * 2) % 16) + f; e.active = cnt; end
            3'd3: begin for (int i = 0; i < cnt; i++) v = (v / 2) + ((v % 2) * 8); e.active = cnt; end
            3'd4: begin for (int i = 0; i < cnt; i++) v = ((v * 2) % 16) + (v / 8); e.active = cnt; end
            3'd5: v = 0;
            default: e.err = 1;
        endcase
        mdl = v;
        e.q = v;
        return e;
    endfunction

    function automatic int exp_mode(input logic [2:0] op);
        case (op)
            3'd0:       return 3;
            3'd1, 3'd3: return 1;
            3'd2, 3'd4: return 2;
            default:    return -1;
        endcase
    endfunction

    // Issue one command; while the block is busy, present junk with cmd_valid high.
    task automatic send(input logic [2:0] op, input logic [3:0] data, input int cnt, input logic fill);
        int w;
        w = 0;
        @(negedge ck);
        while (!cmd_ready && w < 200) begin
            cmd_valid = 1'b1;
            cmd_op    = 3'($urandom);
            cmd_data  = 4'($urandom);
            cmd_cnt   = CNT_W'($urandom);
            cmd_fill  = 1'($urandom);
            w++;
            @(negedge ck);
        end
        if (!cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = op;
            cmd_data  = data;
            cmd_cnt   = CNT_W'(cnt);
            cmd_fill  = fill;
            cur_op    = op;
            cur_fill  = fill;
            sb.push_back(apply(op, data, cnt, fill));
            @(posedge ck);
            @(negedge ck);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge ck);
            w++;
        end
    endtask

    // Response consumer: random backpressure, with a forced-stall window.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge ck);
            #1;
            rsp_ready = (cyc < force_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard compare on handshake plus per-cycle protocol checks.
    int         act_cnt = 0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [3:0] prev_q = 4'd0;
    logic       prev_e = 1'b0;
    exp_t       got;

    always @(negedge ck) begin
        if (clr) begin
            act_cnt = 0;
            prev_v  = 1'b0;
            prev_r  = 1'b0;
        end else begin
            if ({s1, s0} != 2'b00) begin
                act_cnt++;
                check("mode_for_op", int'({s1, s0}), exp_mode(cur_op));
                if ({s1, s0} == 2'b01)
                    check("sri_feedback", int'(sri), (cur_op == 3'd3) ? int'(qd) : int'(cur_fill));
                if ({s1, s0} == 2'b10)
                    check("sli_feedback", int'(sli), (cur_op == 3'd4) ? int'(qa) : int'(cur_fill));
            end
            if (rsp_valid) begin
                check("cmd_ready_in_resp", int'(cmd_ready), 0);
                if (prev_v && !prev_r) begin
                    check("rsp_q_stable", int'(rsp_q), int'(prev_q));
                    check("rsp_err_stable", int'(rsp_err), int'(prev_e));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    got = sb.pop_front();
                    check("rsp_q", int'(rsp_q), got.q);
                    check("rsp_err", int'(rsp_err), got.err);
                    check("active_cycles", act_cnt, got.active);
                    act_cnt = 0;
                end
            end
            prev_v = rsp_valid;
            prev_r = rsp_ready;
            prev_q = rsp_q;
            prev_e = rsp_err;
        end
    end

    initial begin
        int w;
        clr       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 4'd0;
        cmd_cnt   = '0;
        cmd_fill  = 1'b0;

        // Reset state
        repeat (3) @(negedge ck);
        check("rst_sr_clr_n", int'(sr_clr_n), 0);
        check("rst_cmd_ready", int'(cmd_ready), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_err", int'(rsp_err), 0);
        check("rst_mode", int'({s1, s0}), 0);
        check("rst_serial", int'({sli, sri}), 0);
        check("rst_par", int'({a, b, c, d}), 0);
        check("rst_reg", int'({qa, qb, qc, qd}), 0);
        clr = 1'b0;
        @(negedge ck);
        check("ready_after_rst", int'(cmd_ready), 1);
        check("clr_n_after_rst", int'(sr_clr_n), 1);

        // LOAD: one load cycle, response the cycle after E1
        send(3'd0, 4'b0100, 0, 1'b0);
        check("load_mode", int'({s1, s0}), 3);
        check("load_not_yet_valid", int'(rsp_valid), 0);
        @(negedge ck);
        check("load_rsp_latency", int'(rsp_valid), 1);
        check("load_rsp_q_now", int'(rsp_q), 4);

        // LOAD 1000, SHR 3 fill 0 -> 0001
        send(3'd0, 4'b1000, 0, 1'b0);
        send(3'd1, 4'b0000, 3, 1'b0);

        // LOAD 1011, ROL 5 -> 0111
        send(3'd0, 4'b1011, 0, 1'b0);
        send(3'd4, 4'b0000, 5, 1'b0);

        // LOAD 0110, SHL 0 -> immediate response, register untouched
        send(3'd0, 4'b0110, 0, 1'b0);
        send(3'd2, 4'b1111, 0, 1'b1);
        check("zero_cnt_latency", int'(rsp_valid), 1);
        check("zero_cnt_mode", int'({s1, s0}), 0);

        // Illegal opcode held under backpressure
        wait_ready();
        force_until = cyc + 12;
        send(3'd6, 4'b1001, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("ill_valid", int'(rsp_valid), 1);
            check("ill_err", int'(rsp_err), 1);
            check("ill_q", int'(rsp_q), 6);
            check("ill_cmd_ready", int'(cmd_ready), 0);
            @(negedge ck);
        end

        // CLEAR: register reads zero in the response cycle
        send(3'd0, 4'b1101, 0, 1'b0);
        send(3'd5, 4'b0000, 0, 1'b0);
        check("clear_latency", int'(rsp_valid), 1);
        check("clear_q", int'(rsp_q), 0);

        // Reset during a SHR 7 after the third shift edge
        send(3'd0, 4'b1010, 0, 1'b0);
        send(3'd1, 4'b0000, 7, 1'b1);
        repeat (3) @(posedge ck);
        @(negedge ck);
        clr = 1'b1;
        sb.delete();
        mdl = 0;
        @(negedge ck);
        check("abort_rsp_valid", int'(rsp_valid), 0);
        check("abort_mode", int'({s1, s0}), 0);
        check("abort_sr_clr_n", int'(sr_clr_n), 0);
        check("abort_reg", int'({qa, qb, qc, qd}), 0);
        clr = 1'b0;
        cur_op = 3'd0;
        @(negedge ck);
        check("abort_idle_ready", int'(cmd_ready), 1);

        // Random commands
        for (int n = 0; n < 80; n++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom), $urandom_range(0, 7), 1'($urandom));
        end

        // Drain outstanding responses
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            @(negedge ck);
            w++;
        end
        check("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
